// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI-core Wishbone sequencer:
// register map, bit positions, FSM states and control-byte builders.
package spi_seq_pkg;

    localparam logic [2:0] ADR_SPCR = 3'd0;
    localparam logic [2:0] ADR_SPSR = 3'd1;
    localparam logic [2:0] ADR_SPDR = 3'd2;
    localparam logic [2:0] ADR_SPER = 3'd3;
    localparam logic [2:0] ADR_SS   = 3'd4;

    localparam int SPSR_RFEMPTY = 0;
    localparam int SPCR_SPE     = 6;
    localparam int SPCR_MSTR    = 4;
    localparam int SPCR_CPOL    = 3;
    localparam int SPCR_CPHA    = 2;

    typedef enum logic [3:0] {
        CFG0,
        CFG1,
        CFG2,
        SSOFF0,
        READY,
        WSS,
        WDAT,
        POLL,
        RDAT,
        RSP,
        SSREL
    } state_t;

    function automatic logic [7:0] spcr_byte(
        input logic       spe,
        input logic       cpol,
        input logic       cpha,
        input logic [1:0] spr
    );
        logic [7:0] b;
        b            = '0;
        b[SPCR_SPE]  = spe;
        b[SPCR_MSTR] = 1'b1;
        b[SPCR_CPOL] = cpol;
        b[SPCR_CPHA] = cpha;
        b[1:0]       = spr;
        return b;
    endfunction

    function automatic logic [7:0] sper_byte(input logic [1:0] espr);
        return {2'b00, 4'b0000, espr};
    endfunction

endpackage

// File: rtl/spi_wb_access.sv
// Single classic-cycle Wishbone master access engine.
// Launches one access per request and aborts it after ACK_MAX unacked cycles.
module spi_wb_access #(
    parameter int ACK_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [2:0] i_adr,
    input  logic [7:0] i_wdat,
    output logic       o_done,
    output logic       o_timeout,
    output logic [7:0] o_rdat,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [2:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    localparam int CW = $clog2(ACK_MAX + 1);

    logic          r_cyc;
    logic          r_we;
    logic [2:0]    r_adr;
    logic [7:0]    r_dat;
    logic [7:0]    r_rdat;
    logic          r_done;
    logic          r_to;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cyc  <= 1'b0;
            r_we   <= 1'b0;
            r_adr  <= '0;
            r_dat  <= '0;
            r_rdat <= '0;
            r_done <= 1'b0;
            r_to   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            r_to   <= 1'b0;
            if (r_cyc) begin
                if (wb_ack_i) begin
                    r_cyc  <= 1'b0;
                    r_we   <= 1'b0;
                    r_adr  <= '0;
                    r_dat  <= '0;
                    r_rdat <= wb_dat_i;
                    r_done <= 1'b1;
                end else if (r_cnt == CW'(ACK_MAX - 1)) begin
                    r_cyc <= 1'b0;
                    r_we  <= 1'b0;
                    r_adr <= '0;
                    r_dat <= '0;
                    r_to  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (i_req) begin
                // The idle cycle between accesses comes from done being registered.
                r_cyc <= 1'b1;
                r_we  <= i_we;
                r_adr <= i_adr;
                r_dat <= i_wdat;
                r_cnt <= '0;
            end
        end
    end

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign o_rdat    = r_rdat;
    assign o_done    = r_done;
    assign o_timeout = r_to;

endmodule

// File: rtl/spi_wb_sequencer.sv
// Byte-command sequencer driving the simple SPI master core over Wishbone:
// configures the core, then per byte sets SS, writes SPDR, polls SPSR, reads SPDR.
module spi_wb_sequencer
    import spi_seq_pkg::*;
#(
    parameter int POLL_MAX = 1024,
    parameter int ACK_MAX  = 15,
    parameter int SS_W     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cfg_cpol,
    input  logic            cfg_cpha,
    input  logic [3:0]      cfg_div,
    input  logic            cfg_reload,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [SS_W-1:0] cmd_ss,
    input  logic [7:0]      cmd_data,
    input  logic            cmd_last,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_data,
    output logic            err_o,
    output logic            busy_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_adr_o,
    output logic            wb_we_o,
    output logic [7:0]      wb_dat_o,
    input  logic [7:0]      wb_dat_i,
    input  logic            wb_ack_i
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t          r_state;
    logic            r_req;
    logic [SS_W-1:0] r_ss;
    logic [SS_W-1:0] r_cmd_ss;
    logic [7:0]      r_cmd_data;
    logic            r_cmd_last;
    logic [PW-1:0]   r_poll;
    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic            r_err;

    logic            w_we;
    logic [2:0]      w_adr;
    logic [7:0]      w_wdat;
    logic            w_done;
    logic            w_timeout;
    logic [7:0]      w_rdat;

    // Access contents follow the state, so a request launched out of reset
    // picks up the live cfg inputs.
    always_comb begin
        w_we   = 1'b1;
        w_adr  = ADR_SPCR;
        w_wdat = '0;
        unique case (r_state)
            CFG0: w_wdat = spcr_byte(1'b0, cfg_cpol, cfg_cpha, cfg_div[1:0]);
            CFG1: begin
                w_adr  = ADR_SPER;
                w_wdat = sper_byte(cfg_div[3:2]);
            end
            CFG2: w_wdat = spcr_byte(1'b1, cfg_cpol, cfg_cpha, cfg_div[1:0]);
            SSOFF0, SSREL: w_adr = ADR_SS;
            WSS: begin
                w_adr              = ADR_SS;
                w_wdat[SS_W-1:0]   = r_cmd_ss;
            end
            WDAT: begin
                w_adr  = ADR_SPDR;
                w_wdat = r_cmd_data;
            end
            POLL: begin
                w_we  = 1'b0;
                w_adr = ADR_SPSR;
            end
            RDAT: begin
                w_we  = 1'b0;
                w_adr = ADR_SPDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= CFG0;
            r_req       <= 1'b1;
            r_ss        <= '0;
            r_cmd_ss    <= '0;
            r_cmd_data  <= '0;
            r_cmd_last  <= 1'b0;
            r_poll      <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (w_timeout) begin
                r_err       <= 1'b1;
                r_state     <= READY;
                r_cmd_ready <= 1'b1;
            end else begin
                unique case (r_state)
                    CFG0: if (w_done) begin
                        r_state <= CFG1;
                        r_req   <= 1'b1;
                    end
                    CFG1: if (w_done) begin
                        r_state <= CFG2;
                        r_req   <= 1'b1;
                    end
                    CFG2: if (w_done) begin
                        r_state <= SSOFF0;
                        r_req   <= 1'b1;
                    end
                    SSOFF0: if (w_done) begin
                        r_state     <= READY;
                        r_cmd_ready <= 1'b1;
                    end
                    READY: begin
                        if (cmd_valid && r_cmd_ready) begin
                            r_cmd_ss    <= cmd_ss;
                            r_cmd_data  <= cmd_data;
                            r_cmd_last  <= cmd_last;
                            r_cmd_ready <= 1'b0;
                            r_req       <= 1'b1;
                            r_state     <= (cmd_ss != r_ss) ? WSS : WDAT;
                        end else if (cfg_reload) begin
                            r_err       <= 1'b0;
                            r_cmd_ready <= 1'b0;
                            r_req       <= 1'b1;
                            r_state     <= CFG0;
                        end
                    end
                    WSS: if (w_done) begin
                        r_ss    <= r_cmd_ss;
                        r_state <= WDAT;
                        r_req   <= 1'b1;
                    end
                    WDAT: if (w_done) begin
                        r_poll  <= '0;
                        r_state <= POLL;
                        r_req   <= 1'b1;
                    end
                    POLL: if (w_done) begin
                        r_req <= 1'b1;
                        if (!w_rdat[SPSR_RFEMPTY]) begin
                            r_state <= RDAT;
                        end else if (r_poll == PW'(POLL_MAX - 1)) begin
                            r_err   <= 1'b1;
                            r_state <= SSREL;
                        end else begin
                            r_poll <= r_poll + 1'b1;
                        end
                    end
                    RDAT: if (w_done) begin
                        r_rsp_data  <= w_rdat;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end
                    RSP: if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_cmd_last) begin
                            r_state <= SSREL;
                            r_req   <= 1'b1;
                        end else begin
                            r_state     <= READY;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                    SSREL: if (w_done) begin
                        r_ss        <= '0;
                        r_state     <= READY;
                        r_cmd_ready <= 1'b1;
                    end
                    default: r_state <= CFG0;
                endcase
            end
        end
    end

    spi_wb_access #(
        .ACK_MAX(ACK_MAX)
    ) u_access (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_req    (r_req),
        .i_we     (w_we),
        .i_adr    (w_adr),
        .i_wdat   (w_wdat),
        .o_done   (w_done),
        .o_timeout(w_timeout),
        .o_rdat   (w_rdat),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i)
    );

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign err_o     = r_err;
    assign busy_o    = (r_state != READY);

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Directed bench for spi_wb_sequencer with a behavioural SPI-core register slave.
// Bus accesses are logged and compared against hand-written expected sequences.
module tb_spi_wb_sequencer;

    logic       clk;
    logic       rst;
    logic       cfg_cpol;
    logic       cfg_cpha;
    logic [3:0] cfg_div;
    logic       cfg_reload;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ss;
    logic [7:0] cmd_data;
    logic       cmd_last;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       err_o;
    logic       busy_o;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic [2:0] wb_adr_o;
    logic       wb_we_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;

    logic       ack_en;
    logic       stuck;
    int         n_empty;
    int         spsr_base;
    logic [7:0] spdr_val;
    logic       rfempty;

    int         spsr_reads;
    int         rsp_seen;
    int         cyc_cnt;
    logic [11:0] log_q[$];

    int n_chk;
    int n_err;
    int t_acc;
    int t_rsp;

    spi_wb_sequencer #(
        .POLL_MAX(8),
        .ACK_MAX (15),
        .SS_W    (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .cfg_cpol  (cfg_cpol),
        .cfg_cpha  (cfg_cpha),
        .cfg_div   (cfg_div),
        .cfg_reload(cfg_reload),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ss    (cmd_ss),
        .cmd_data  (cmd_data),
        .cmd_last  (cmd_last),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .err_o     (err_o),
        .busy_o    (busy_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_adr_o  (wb_adr_o),
        .wb_we_o   (wb_we_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait slave: ack in the first strobe cycle.
    assign rfempty  = stuck || ((spsr_reads - spsr_base) < n_empty);
    assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en;
    assign wb_dat_i = (wb_adr_o == 3'd1) ? {7'b0, rfempty} : spdr_val;

    initial begin
        spsr_reads = 0;
        rsp_seen   = 0;
        cyc_cnt    = 0;
    end

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rsp_valid)
            rsp_seen <= rsp_seen + 1;
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            log_q.push_back({wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : wb_dat_i});
            if (!wb_we_o && wb_adr_o == 3'd1)
                spsr_reads <= spsr_reads + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] E(input logic we, input logic [2:0] a,
                                      input logic [7:0] d);
        return {we, a, d};
    endfunction

    task automatic chk_at(input string tag, input int idx,
                          input logic [11:0] exp);
        logic [11:0] g;
        g = (idx < log_q.size()) ? log_q[idx] : 12'hFFF;
        chk(tag, {20'b0, g}, {20'b0, exp});
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cmd_ready, 1);
    endtask

    task automatic send(input logic [1:0] ss, input logic [7:0] d,
                        input logic last);
        wait_ready("send_rdy", 200);
        cmd_ss    = ss;
        cmd_data  = d;
        cmd_last  = last;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t_acc     = cyc_cnt;
    endtask

    task automatic get_rsp(input string tag, output logic [7:0] d);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rv"}, rsp_valid, 1);
        d         = rsp_data;
        t_rsp     = cyc_cnt;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b;
        int n;
        int bad_v;
        int bad_d;
        int bad_bus;
        int bad_rdy;
        logic [7:0] d;

        n_chk      = 0;
        n_err      = 0;
        rst        = 1'b1;
        cfg_cpol   = 1'b1;
        cfg_cpha   = 1'b0;
        cfg_div    = 4'b0110;
        cfg_reload = 1'b0;
        cmd_valid  = 1'b0;
        cmd_ss     = '0;
        cmd_data   = '0;
        cmd_last   = 1'b0;
        rsp_ready  = 1'b0;
        ack_en     = 1'b1;
        stuck      = 1'b0;
        n_empty    = 0;
        spsr_base  = 0;
        spdr_val   = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_flags", {cmd_ready, rsp_valid, err_o, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("rst_busy", busy_o, 1);
        chk("rst_bus", {wb_adr_o, wb_dat_o, rsp_data}, 0);

        // Configuration sequence
        b   = log_q.size();
        rst = 1'b0;
        wait_ready("cfg_rdy", 100);
        chk("cfg_len", log_q.size() - b, 4);
        chk_at("cfg_spcr0", b + 0, E(1, 3'd0, 8'h1A));
        chk_at("cfg_sper", b + 1, E(1, 3'd3, 8'h01));
        chk_at("cfg_spcr1", b + 2, E(1, 3'd0, 8'h5A));
        chk_at("cfg_ssoff", b + 3, E(1, 3'd4, 8'h00));
        chk("cfg_busy", busy_o, 0);

        // Single last byte, two empty polls
        b         = log_q.size();
        spsr_base = spsr_reads;
        n_empty   = 2;
        spdr_val  = 8'h3C;
        send(2'b01, 8'hA5, 1'b1);
        get_rsp("t2", d);
        chk("t2_rx", d, 8'h3C);
        wait_ready("t2_rdy", 100);
        chk("t2_len", log_q.size() - b, 7);
        chk_at("t2_ss", b + 0, E(1, 3'd4, 8'h01));
        chk_at("t2_spdr", b + 1, E(1, 3'd2, 8'hA5));
        chk_at("t2_p0", b + 2, E(0, 3'd1, 8'h01));
        chk_at("t2_p1", b + 3, E(0, 3'd1, 8'h01));
        chk_at("t2_p2", b + 4, E(0, 3'd1, 8'h00));
        chk_at("t2_rd", b + 5, E(0, 3'd2, 8'h3C));
        chk_at("t2_rel", b + 6, E(1, 3'd4, 8'h00));
        chk("t2_polls", spsr_reads - spsr_base, 3);

        // Two bytes to the same slave
        b         = log_q.size();
        spsr_base = spsr_reads;
        n_empty   = 0;
        spdr_val  = 8'h5E;
        send(2'b01, 8'h11, 1'b0);
        get_rsp("t3a", d);
        chk("t3a_rx", d, 8'h5E);
        send(2'b01, 8'h22, 1'b1);
        get_rsp("t3b", d);
        chk("t3_lat", t_rsp - t_acc, 9);
        wait_ready("t3_rdy", 100);
        chk("t3_len", log_q.size() - b, 8);
        chk_at("t3_ss", b + 0, E(1, 3'd4, 8'h01));
        chk_at("t3_d0", b + 1, E(1, 3'd2, 8'h11));
        chk_at("t3_r0", b + 3, E(0, 3'd2, 8'h5E));
        chk_at("t3_d1", b + 4, E(1, 3'd2, 8'h22));
        chk_at("t3_p1", b + 5, E(0, 3'd1, 8'h00));
        chk_at("t3_rel", b + 7, E(1, 3'd4, 8'h00));

        // Response back-pressure
        spdr_val = 8'hC3;
        send(2'b01, 8'h77, 1'b1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        bad_v   = 0;
        bad_d   = 0;
        bad_bus = 0;
        bad_rdy = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rsp_valid) bad_v++;
            if (rsp_data !== 8'hC3) bad_d++;
            if (wb_cyc_o) bad_bus++;
            if (cmd_ready) bad_rdy++;
            @(negedge clk);
        end
        chk("t4_hold_valid", bad_v, 0);
        chk("t4_hold_data", bad_d, 0);
        chk("t4_no_bus", bad_bus, 0);
        chk("t4_no_ready", bad_rdy, 0);
        get_rsp("t4", d);
        chk("t4_rx", d, 8'hC3);
        wait_ready("t4_rdy", 100);

        // Poll timeout, then reload with a new configuration
        b         = log_q.size();
        spsr_base = spsr_reads;
        n         = rsp_seen;
        stuck     = 1'b1;
        send(2'b10, 8'h99, 1'b0);
        wait_ready("t5_rdy", 300);
        chk("t5_polls", spsr_reads - spsr_base, 8);
        chk("t5_err", err_o, 1);
        chk("t5_norsp", rsp_seen - n, 0);
        chk("t5_len", log_q.size() - b, 11);
        chk_at("t5_ss", b + 0, E(1, 3'd4, 8'h02));
        chk_at("t5_rel", b + 10, E(1, 3'd4, 8'h00));
        stuck      = 1'b0;
        cfg_cpol   = 1'b0;
        cfg_cpha   = 1'b1;
        cfg_div    = 4'b1001;
        b          = log_q.size();
        cfg_reload = 1'b1;
        @(negedge clk);
        cfg_reload = 1'b0;
        chk("t5_errclr", err_o, 0);
        chk("t5_busy", busy_o, 1);
        wait_ready("t5_cfg_rdy", 100);
        chk("t5_cfg_len", log_q.size() - b, 4);
        chk_at("t5_spcr0", b + 0, E(1, 3'd0, 8'h15));
        chk_at("t5_sper", b + 1, E(1, 3'd3, 8'h02));
        chk_at("t5_spcr1", b + 2, E(1, 3'd0, 8'h55));
        chk_at("t5_ssoff", b + 3, E(1, 3'd4, 8'h00));

        // Slave never acknowledges
        ack_en = 1'b0;
        send(2'b01, 8'h42, 1'b1);
        n = 0;
        while (!wb_cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (wb_cyc_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t6_cyc_len", n, 15);
        chk("t6_cyc_low", wb_cyc_o, 0);
        wait_ready("t6_rdy", 20);
        chk("t6_err", err_o, 1);

        // Reset during an access
        send(2'b01, 8'h43, 1'b1);
        n = 0;
        while (!wb_cyc_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t7_cyc_up", wb_cyc_o, 1);
        rst = 1'b1;
        #1;
        chk("t7_cyc_drop", {wb_cyc_o, wb_stb_o}, 0);
        chk("t7_err_rst", err_o, 0);
        chk("t7_busy", busy_o, 1);
        @(negedge clk);
        ack_en = 1'b1;
        b      = log_q.size();
        rst    = 1'b0;
        wait_ready("t7_rdy", 100);
        chk("t7_cfg_len", log_q.size() - b, 4);
        chk_at("t7_spcr1", b + 2, E(1, 3'd0, 8'h55));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_wb_sequencer.md
Name: spi_wb_sequencer

Overview:
- Wishbone master that configures and drives the 8-bit simple SPI master core through its register bus; it has no datapath of its own.
- Accepts byte commands (slave select, TX byte, last flag) on a valid/ready port. For each command it writes the slave-select register, writes the data register, polls status, then reads the RX byte back.
- Sits between the system command logic and the SPI core's Wishbone slave port, so software never touches SPI registers directly.

Parameters:
- POLL_MAX, 1024, maximum SPSR reads per byte before timeout error.
- ACK_MAX, 15, maximum cycles waiting for wb_ack_i before bus error.
- SS_W, 2, slave-select width; matches SPI core ss_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cfg_cpol  in  1  SPI clock polarity
- cfg_cpha  in  1  SPI clock phase
- cfg_div  in  4  clock divider; [1:0] goes to SPCR.SPR, [3:2] goes to SPER.ESPR
- cfg_reload  in  1  pulse: rerun configuration sequence when idle
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted this cycle
- cmd_ss  in  SS_W  one-hot slave select for this byte
- cmd_data  in  8  TX byte
- cmd_last  in  1  release slave select after this byte
- rsp_valid  out  1  RX byte valid
- rsp_ready  in  1  RX byte consumed
- rsp_data  out  8  RX byte
- err_o  out  1  sticky error (poll or ack timeout); cleared by cfg_reload
- busy_o  out  1  high whenever the state is not READY
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_adr_o  out  3  register address
- wb_we_o  out  1  write enable
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_ack_i  in  1  bus acknowledge

Behaviour:
- Reset values:
  - All outputs are 0: cmd_ready, rsp_valid, err_o, wb_*, rsp_data.
  - busy_o is 1 because the state is CFG0.
  - The current-SS register is 0.
  - Asserting rst_i mid-cycle drops wb_cyc_o/wb_stb_o immediately; the SPI core is left as-is and is reconfigured by the CFG sequence.
- Register map:
  - SPCR=0, SPSR=1, SPDR=2, SPER=3, SS=4.
  - SPSR bit0 = RFEMPTY.
  - SPCR = {SPIE=0, SPE, 1'b0, MSTR=1, CPOL, CPHA, SPR}.
  - SPER = {ICNT=2'b00, 4'b0, ESPR}.
- Bus access rules:
  - Each access is a single classic cycle.
  - wb_cyc_o, wb_stb_o, adr, we and dat are asserted together and held until wb_ack_i.
  - All are deasserted the cycle after ack; read data is captured on ack.
  - At least one idle cycle separates accesses.
  - If ACK_MAX cycles pass without ack: abort the access, set err_o, go to READY.
- State sequence:
  - CFG0: write SPCR with SPE=0.
  - CFG1: write SPER.
  - CFG2: write SPCR with SPE=1.
  - SSOFF0: write SS=0. Then go to READY.
- READY:
  - cmd_ready=1 and busy_o=0.
  - On cmd_valid&cmd_ready, latch ss/data/last. Go to WSS if cmd_ss differs from current-SS, else go to WDAT.
  - cfg_reload pulsed in READY (no command accepted that cycle) clears err_o and goes to CFG0.
  - cfg_reload is ignored in all other states.
- WSS: write SS=cmd_ss and update current-SS.
- WDAT: write SPDR=data and clear the poll counter.
- POLL:
  - Read SPSR. If RFEMPTY=0, go to RDAT.
  - Otherwise increment the poll counter and repeat.
  - When the counter reaches POLL_MAX: set err_o, go to SSREL with the byte dropped and no response.
- RDAT: read SPDR into rsp_data.
- RSP:
  - Hold rsp_valid=1 with rsp_data stable until rsp_ready.
  - If last, go to SSREL; otherwise go to READY.
  - rsp_valid and rsp_ready high in the same cycle completes the response.
- SSREL: write SS=0, set current-SS=0, go to READY.
- SS handling: a new command to a different slave while SS is held does a direct SS rewrite with no release first. Consecutive non-last bytes to the same slave skip WSS.
- Timing: cmd_ready is a single-cycle pulse per accepted command; there is no pipelining and one byte is in flight at a time.
- Minimum latency, accept to rsp_valid (zero-wait slave with 1-cycle ack, same SS, first poll succeeds): 9 cycles.

Decomposition:
- Package spi_seq_pkg holds:
  - the register address localparams;
  - the SPCR/SPSR bit indices;
  - the state enum (CFG0, CFG1, CFG2, SSOFF0, READY, WSS, WDAT, POLL, RDAT, RSP, SSREL);
  - helper functions that build the SPCR and SPER bytes.
- One sub-module, spi_wb_access: a single-access Wishbone master engine (req/we/adr/wdat in; done/rdat/timeout out; owns the ACK_MAX counter). The sequencer FSM issues requests to it.

Test Plan:
- Reset, then cfg cpol=1, cpha=0, div=4'b0110 -> writes in order: adr0=8'h1A, adr3=8'h01, adr0=8'h5A, adr4=8'h00; then cmd_ready=1.
- cmd ss=2'b01, data=8'hA5, last=1; model returns RFEMPTY=1 twice, then 0, and SPDR=8'h3C -> writes SS=01, SPDR=A5; three SPSR reads; rsp_data=3C; then writes SS=00.
- Two bytes 8'h11 (last=0) and 8'h22 (last=1), both ss=01 -> SS=01 written once, no SS write between the bytes, SS=00 after the second response.
- Hold rsp_ready=0 for 20 cycles -> rsp_valid stays high, rsp_data stable, no Wishbone activity, cmd_ready=0.
- RFEMPTY held at 1 with POLL_MAX=8 -> exactly 8 SPSR reads, err_o=1, no rsp_valid, SS=00 written. Then cfg_reload -> err_o=0 and the CFG sequence reruns.
- Slave never acks -> after ACK_MAX cycles wb_cyc_o drops and err_o=1. Separately, assert rst_i mid-access -> wb_cyc_o=0 in the same cycle.
